// File: rtl/mips_core_pkg.sv
// Shared core-wide types and sizing for the out-of-order MIPS pipeline.
// The reorder buffer and instruction queue size themselves from ROB_DEPTH.
package mips_core_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_PREG_W = 6;
    localparam int ROB_AREG_W = 5;
    localparam int ROB_PC_W   = 26;
    localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0]  rob_tag_t;
    typedef logic [ROB_PREG_W-1:0] preg_t;
    typedef logic [ROB_AREG_W-1:0] areg_t;
    typedef logic [ROB_PC_W-1:0]   pc_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  mispredict;
        logic  uses_rd;
        areg_t arch_rd;
        preg_t new_preg;
        preg_t old_preg;
        pc_t   pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, completes out of order,
// retires from the head and raises a one-cycle flush when a mispredicted branch retires.
module reorder_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int PREG_W = ROB_PREG_W,
    parameter int AREG_W = ROB_AREG_W,
    parameter int PC_W   = ROB_PC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic                     alloc_uses_rd,
    input  logic [AREG_W-1:0]        alloc_arch_rd,
    input  logic [PREG_W-1:0]        alloc_new_preg,
    input  logic [PREG_W-1:0]        alloc_old_preg,
    input  logic [PC_W-1:0]          alloc_pc,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    input  logic                     complete_valid,
    input  logic [$clog2(DEPTH)-1:0] complete_tag,
    input  logic                     complete_mispredict,
    output logic                     commit_valid,
    output logic                     commit_uses_rd,
    output logic [AREG_W-1:0]        commit_arch_rd,
    output logic [PREG_W-1:0]        commit_new_preg,
    output logic [PREG_W-1:0]        commit_old_preg,
    output logic [PC_W-1:0]          commit_pc,
    output logic                     flush,
    output logic [PC_W-1:0]          flush_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_mispredict;
    logic [DEPTH-1:0]  r_uses_rd;
    logic [AREG_W-1:0] r_arch_rd  [DEPTH];
    logic [PREG_W-1:0] r_new_preg [DEPTH];
    logic [PREG_W-1:0] r_old_preg [DEPTH];
    logic [PC_W-1:0]   r_pc       [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic w_alloc;
    logic w_commit;
    logic w_flush;
    logic w_complete;

    assign w_commit    = r_valid[r_head] & r_done[r_head];
    assign w_flush     = w_commit & r_mispredict[r_head];
    assign alloc_ready = (r_count < FULL_CNT) & ~w_flush;
    assign w_alloc     = alloc_valid & alloc_ready;
    // Completions to empty slots are dropped; allocation at the same slot then wins.
    assign w_complete  = complete_valid & r_valid[complete_tag];

    assign alloc_tag       = r_tail;
    assign count           = r_count;
    assign commit_valid    = w_commit;
    assign commit_uses_rd  = r_uses_rd[r_head];
    assign commit_arch_rd  = r_arch_rd[r_head];
    assign commit_new_preg = r_new_preg[r_head];
    assign commit_old_preg = r_old_preg[r_head];
    assign commit_pc       = r_pc[r_head];
    assign flush           = w_flush;
    assign flush_pc        = r_pc[r_head];

    // Entry status bits, pointers and occupancy; a flush wipes everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_mispredict <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else if (w_flush) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_mispredict <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else begin
            if (w_complete) begin
                r_done[complete_tag]       <= 1'b1;
                r_mispredict[complete_tag] <= complete_mispredict;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + TAG_W'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail]      <= 1'b1;
                r_done[r_tail]       <= 1'b0;
                r_mispredict[r_tail] <= 1'b0;
                r_tail               <= r_tail + TAG_W'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_uses_rd[r_tail]  <= alloc_uses_rd;
            r_arch_rd[r_tail]  <= alloc_arch_rd;
            r_new_preg[r_tail] <= alloc_new_preg;
            r_old_preg[r_tail] <= alloc_old_preg;
            r_pc[r_tail]       <= alloc_pc;
        end else begin
            r_uses_rd[r_tail]  <= r_uses_rd[r_tail];
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order MIPS core, sitting directly downstream of rename (register map table / free list) and alongside the instruction queue. It allocates one entry per renamed instruction in program order and records completions from writeback in any order. It retires completed entries in order, returning the superseded physical register to the free list. A mispredicted branch that reaches the head triggers a full pipeline flush.

## Interface
- DEPTH, 16: entry count; power of two, >= 4.
- PREG_W, 6: physical register tag width (64 physical registers).
- AREG_W, 5: architectural register index width.
- PC_W, 26: byte-address width of recorded PC.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  entry available; an allocation occurs when alloc_valid && alloc_ready.
- alloc_uses_rd  in  1  instruction writes a register.
- alloc_arch_rd  in  AREG_W  destination architectural register.
- alloc_new_preg  in  PREG_W  newly mapped physical register.
- alloc_old_preg  in  PREG_W  previous mapping of alloc_arch_rd.
- alloc_pc  in  PC_W  instruction PC.
- alloc_tag  out  $clog2(DEPTH)  index assigned to the allocating instruction (tail pointer).
- complete_valid  in  1  writeback reports a finished instruction.
- complete_tag  in  $clog2(DEPTH)  index being completed.
- complete_mispredict  in  1  completing branch was mispredicted.
- commit_valid  out  1  head entry retires this cycle.
- commit_uses_rd, commit_arch_rd, commit_new_preg, commit_old_preg, commit_pc  out  widths as alloc_*  fields of the retiring entry; commit_old_preg is returned to the free list.
- flush  out  1  one-cycle flush request.
- flush_pc  out  PC_W  PC of the mispredicted branch; the fetch unit derives the redirect from it.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Per-entry state: valid, done, mispredict, uses_rd, arch_rd, new_preg, old_preg, pc.
- head/tail pointers: $clog2(DEPTH) bits each, wrap naturally modulo DEPTH.
- count: separate register, range 0..DEPTH.
- Allocate:
  - alloc_ready = (count < DEPTH) && !flush.
  - On allocation, write the entry at tail with valid=1, done=0 and mispredict=0, then increment tail.
- Complete:
  - If complete_valid and entry[complete_tag].valid, set done=1 and mispredict=complete_mispredict.
  - Completion to an invalid entry is ignored.
  - Repeat completion of a done entry overwrites mispredict.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done.
  - The commit_* outputs are driven from entry[head].
  - On commit, clear entry[head].valid and increment head.
- Flush:
  - flush = commit_valid && entry[head].mispredict; flush_pc = entry[head].pc.
  - The branch itself still commits in that cycle.
  - At the following edge: all valid bits clear, head=tail=0, count=0.
  - Any completion in the flush cycle is discarded.
- Count update: count += alloc − commit per cycle; both may occur in the same cycle.
- All state is registered; no combinational path from complete_* to commit_*.

## Timing
- Reset (asynchronous): head=tail=0, count=0, all valid/done clear.
  - Output values in reset: alloc_ready=1, alloc_tag=0, commit_valid=0, flush=0, count=0.
  - Other commit_* fields are don't-care when commit_valid=0.
- Allocation: entry visible at the next edge. The earliest completion for it is in the cycle after allocation.
- Completion: done is registered. The earliest commit is in the cycle after the completion edge, so completion-to-commit latency is 1 cycle.
- At most one allocation, one completion and one commit per cycle.
- Full (count==DEPTH): alloc_ready=0 even if a commit occurs in the same cycle. alloc_ready rises the cycle after the commit.
- Empty: commit_valid=0. An entry allocated and completed back-to-back commits no earlier than 2 cycles after allocation.
- Wrap-around: tail==head with count==DEPTH means full; with count==0 it means empty.
- Allocation and completion of the same index in one cycle: allocation wins (done=0), and the completion is ignored because the entry was invalid.
- Reset mid-operation discards all entries immediately.

## Structure
- Add to mips_core_pkg:
  - typedef rob_tag_t (logic [$clog2(DEPTH)-1:0]);
  - typedef preg_t (logic [PREG_W-1:0]);
  - packed struct rob_entry_t;
  - ROB_DEPTH constant shared with the instruction queue.
- No sub-module: entry array, pointer and count logic live in reorder_buffer.

## Test plan
- Reset, then allocate 3 entries (pc 0x100/0x104/0x108), complete tags 2,0,1 in that order → commits occur in order 0x100, 0x104, 0x108; commit_old_preg values match the allocated ones; count returns to 0.
- Allocate 16 entries → alloc_ready=0 at count=16 with tail wrapped to 0. Complete tag 0 → commit the next cycle, alloc_ready=1 the cycle after that.
- Allocate 4 entries; complete tag 1 with complete_mispredict=1 and tag 0 normally → tag 0 commits, then tag 1 commits with flush=1 and flush_pc equal to its pc. The next cycle count=0, head=tail=0, and tags 2–3 never commit.
- Complete in the same cycle as a commit and an allocation → count unchanged; both operations take effect.
- Complete an unallocated tag (5 while count=2) → no state change and no commit.
- Assert rst_n low with 6 entries pending → outputs immediately take their reset values; the first allocation after release gets alloc_tag=0.
